// File: rtl/avr_cpu_regfile.sv
// AVR general-purpose register file: two combinational read ports, byte/pair write, X/Y/Z pointer unit.
// Optional same-cycle write forwarding on all read outputs when REGFILE_BYPASS_EN is defined.
module avr_cpu_regfile #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned REG_COUNT  = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic                    ready,
   input  logic [ADDR_WIDTH-1:0]   r_addr,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   output logic [DATA_WIDTH-1:0]   r_out,
   output logic [DATA_WIDTH-1:0]   d_out,
   input  logic                    wr_en,
   input  logic                    wr_word,
   input  logic [2*DATA_WIDTH-1:0] wr_data,
   input  logic [1:0]              ptr_sel,
   input  logic [1:0]              ptr_op,
   output logic [2*DATA_WIDTH-1:0] ptr_out,
   output logic [2*DATA_WIDTH-1:0] x,
   output logic [2*DATA_WIDTH-1:0] y,
   output logic [2*DATA_WIDTH-1:0] z
);

   localparam int unsigned PW    = 2 * DATA_WIDTH;
   localparam int unsigned CNT_W = $clog2(REG_COUNT);

   localparam logic [ADDR_WIDTH-1:0] X_LO = ADDR_WIDTH'(REG_COUNT - 6);
   localparam logic [ADDR_WIDTH-1:0] X_HI = ADDR_WIDTH'(REG_COUNT - 5);
   localparam logic [ADDR_WIDTH-1:0] Y_LO = ADDR_WIDTH'(REG_COUNT - 4);
   localparam logic [ADDR_WIDTH-1:0] Y_HI = ADDR_WIDTH'(REG_COUNT - 3);
   localparam logic [ADDR_WIDTH-1:0] Z_LO = ADDR_WIDTH'(REG_COUNT - 2);
   localparam logic [ADDR_WIDTH-1:0] Z_HI = ADDR_WIDTH'(REG_COUNT - 1);

   typedef enum logic {SWEEP, RUN} state_t;

   state_t                state;
   logic [CNT_W-1:0]      sweep_cnt;

   logic [DATA_WIDTH-1:0] regs     [REG_COUNT];
   logic [DATA_WIDTH-1:0] wr_view  [REG_COUNT];
   logic [DATA_WIDTH-1:0] bank_nxt [REG_COUNT];
   logic [DATA_WIDTH-1:0] rd_bank  [REG_COUNT];
   logic [DATA_WIDTH-1:0] pt_bank  [REG_COUNT];

   logic                  run;
   logic                  wr_go;
   logic                  ptr_act;
   logic                  ptr_upd;
   logic                  coll;
   logic [ADDR_WIDTH-1:0] p_lo;
   logic [ADDR_WIDTH-1:0] p_hi;
   logic [ADDR_WIDTH-1:0] w_even;
   logic [ADDR_WIDTH-1:0] w_odd;
   logic [PW-1:0]         p_cur;
   logic [PW-1:0]         p_new;
   logic [PW-1:0]         p_fwd;

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return 32'(a) < REG_COUNT;
   endfunction

   // Init sweep sequencer; ready rises the edge after register REG_COUNT-1 is cleared
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= SWEEP;
         sweep_cnt <= '0;
         ready     <= 1'b0;
      end else begin
         case (state)
            SWEEP: begin
               sweep_cnt <= sweep_cnt + CNT_W'(1);
               if (sweep_cnt == CNT_W'(REG_COUNT - 1)) begin
                  state <= RUN;
                  ready <= 1'b1;
               end
            end
            RUN:     state <= RUN;
            default: state <= SWEEP;
         endcase
      end
   end

   // Pointer pair selection, collision detection and increment/decrement
   always_comb begin
      run     = (state == RUN);
      wr_go   = run && wr_en && in_range(d_addr);
      w_even  = {d_addr[ADDR_WIDTH-1:1], 1'b0};
      w_odd   = {d_addr[ADDR_WIDTH-1:1], 1'b1};
      ptr_act = 1'b1;
      p_lo    = '0;
      p_hi    = '0;
      case (ptr_sel)
         2'b01:   begin p_lo = X_LO; p_hi = X_HI; end
         2'b10:   begin p_lo = Y_LO; p_hi = Y_HI; end
         2'b11:   begin p_lo = Z_LO; p_hi = Z_HI; end
         default: ptr_act = 1'b0;
      endcase
      coll    = wr_go && (wr_word ? (w_even == p_lo) : (d_addr == p_lo || d_addr == p_hi));
      ptr_upd = run && ptr_act && (ptr_op == 2'b01 || ptr_op == 2'b10) && !coll;
      p_cur   = {regs[p_hi], regs[p_lo]};
      p_new   = (ptr_op == 2'b01) ? p_cur + PW'(1) : p_cur - PW'(1);
   end

   // Next bank image: explicit write first, then pointer update, or one sweep clear
   always_comb begin
      wr_view = regs;
      if (wr_go) begin
         if (wr_word) begin
            wr_view[w_even] = wr_data[DATA_WIDTH-1:0];
            wr_view[w_odd]  = wr_data[PW-1:DATA_WIDTH];
         end else begin
            wr_view[d_addr] = wr_data[DATA_WIDTH-1:0];
         end
      end
      bank_nxt = wr_view;
      if (ptr_upd) begin
         bank_nxt[p_lo] = p_new[DATA_WIDTH-1:0];
         bank_nxt[p_hi] = p_new[PW-1:DATA_WIDTH];
      end
      if (!run) begin
         bank_nxt[sweep_cnt] = '0;
      end
   end

   // Storage is deliberately unreset; the sweep establishes its contents
   always_ff @(posedge clk) begin
      regs <= bank_nxt;
   end

   always_comb begin
`ifdef REGFILE_BYPASS_EN
      rd_bank = bank_nxt;
      pt_bank = wr_view;
`else
      rd_bank = regs;
      pt_bank = regs;
`endif
   end

   // Read ports, masked to zero until the sweep completes
   always_comb begin
      r_out   = '0;
      d_out   = '0;
      ptr_out = '0;
      x       = '0;
      y       = '0;
      z       = '0;
      p_fwd   = {pt_bank[p_hi], pt_bank[p_lo]};
      if (ready) begin
         if (in_range(r_addr)) r_out = rd_bank[r_addr];
         if (in_range(d_addr)) d_out = rd_bank[d_addr];
         x = {rd_bank[X_HI], rd_bank[X_LO]};
         y = {rd_bank[Y_HI], rd_bank[Y_LO]};
         z = {rd_bank[Z_HI], rd_bank[Z_LO]};
         if (ptr_act) begin
            ptr_out = (ptr_op == 2'b10) ? p_fwd - PW'(1) : p_fwd;
         end
      end
   end

endmodule

// File: doc/avr_cpu_regfile.md
Name: avr_cpu_regfile

Overview:
- Parametrised AVR general-purpose register file that succeeds the single-write, Z-only register block.
- Provides two combinational read ports and one byte- or word-wide write port.
- Holds X/Y/Z pointer pairs with a hardware post-increment/pre-decrement unit.
- A zero-fill sweep after reset brings the bank to a known state. Sits between the decoder/ALU and the data-memory address path.

Parameters:
- DATA_WIDTH, 8, register width in bits.
- REG_COUNT, 32, number of registers; even, at least 32 (X/Y/Z live at top six).
- ADDR_WIDTH, 5, register address width; 2**ADDR_WIDTH >= REG_COUNT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- ready  out  1  high once init sweep is complete.
- r_addr  in  ADDR_WIDTH  read port R address.
- d_addr  in  ADDR_WIDTH  read port D address and write address.
- r_out  out  DATA_WIDTH  register[r_addr].
- d_out  out  DATA_WIDTH  register[d_addr].
- wr_en  in  1  write strobe.
- wr_word  in  1  0 = byte write; 1 = pair write to {d_addr|1, d_addr&~1}.
- wr_data  in  2*DATA_WIDTH  byte write uses low DATA_WIDTH bits; pair write: low half to even register, high half to odd.
- ptr_sel  in  2  00 none, 01 X (r26/r27), 10 Y (r28/r29), 11 Z (r30/r31).
- ptr_op  in  2  00 hold, 01 post-increment, 10 pre-decrement, 11 hold.
- ptr_out  out  2*DATA_WIDTH  effective address for the selected pointer.
- x, y, z  out  2*DATA_WIDTH each  pointer pairs; even register = low byte.

Behaviour:
- Reset (async, active-high):
  - FSM enters SWEEP; sweep counter = 0; ready = 0.
  - r_out, d_out, ptr_out, x, y, z forced to 0 while ready = 0.
- SWEEP state:
  - Writes 0 to register[counter] each cycle, counter++.
  - After the cycle writing REG_COUNT-1, go to RUN; ready = 1 from the next cycle. Total REG_COUNT cycles after rst deassert.
  - wr_en and ptr_op ignored during SWEEP.
  - rst mid-sweep restarts at counter 0.
- RUN state:
  - Stays in RUN until rst.
  - Reads are combinational from the bank (no same-cycle bypass unless the optional feature is compiled in).
- Byte write: wr_en=1, wr_word=0 -> register[d_addr] <= wr_data[DATA_WIDTH-1:0] at clk edge.
- Pair write: wr_en=1, wr_word=1 -> even register <= low half, odd register <= high half, same edge; d_addr[0] ignored.
- Addresses >= REG_COUNT: writes dropped; reads return 0.
- Pointer unit (RUN, ptr_sel != 00):
  - Post-increment: ptr_out = P; P <= P+1 at edge.
  - Pre-decrement: ptr_out = P-1 combinationally; P <= P-1 at edge.
  - Hold: ptr_out = P; no update.
  - ptr_sel = 00: ptr_out = 0.
  - Arithmetic is modulo 2**(2*DATA_WIDTH): 0xFFFF+1 -> 0x0000, 0x0000-1 -> 0xFFFF (DATA_WIDTH=8).
- Collision: if an explicit write targets either byte of the selected pointer pair in the same cycle, the explicit write wins and the pointer update is suppressed for both bytes.
- No multi-cycle operations in RUN: all writes and pointer updates complete in one edge; no stall output.

Optional Feature:
- REGFILE_BYPASS_EN defined:
  - r_out/d_out return the data being written this cycle when the read address matches a written register (byte or either half of a pair).
  - x, y, z, ptr_out forward the same way, including the pending pointer update result for x/y/z.
- Undefined: all outputs show pre-edge bank contents; new values are visible the cycle after the edge.

Test Plan:
- Reset sweep: pulse rst, hold idle -> ready low exactly 32 cycles then high; all registers read 0x00; x = y = z = 0x0000.
- Byte/pair write: byte write d_addr=5, data 0xA5 -> r_out(r_addr=5)=0xA5 next cycle. Pair write d_addr=25 (wr_word=1), wr_data=0x1234 -> r24=0x34, r25=0x12.
- Pointer post-inc wrap: Z loaded 0xFFFF; ptr_sel=11, ptr_op=01 -> ptr_out=0xFFFF that cycle; z=0x0000 next cycle.
- Pointer pre-dec: X=0x0100; ptr_sel=01, ptr_op=10 -> ptr_out=0x00FF same cycle; x=0x00FF next cycle.
- Collision: Y=0x0010, post-inc Y with same-cycle byte write d_addr=28, data 0x77 -> y=0x0077 (no increment).
- Mid-sweep reset and bypass: rst at sweep cycle 10 -> ready stays low 32 further cycles. With REGFILE_BYPASS_EN, write r3=0x5A while r_addr=3 -> r_out=0x5A same cycle; without the macro, r_out shows the old value.
